seq_divider: RTL and testbench

//   Multicycle signed 32-bit integer divider for the MIPS datapath (DIV instruction).

---
 rtl/seq_divider.sv | 136 +++++++++++++
 tb/tb_seq_divider.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multicycle signed restoring divider for the MIPS DIV instruction.
// Quotient goes to LO and remainder to HI, WIDTH iterations per operation.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             DivZero,
  output logic             DivStop,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             signQ_q, signQ_d;
  logic             signR_q, signR_d;
  logic             zero_q, zero_d;
  logic             stop_q, stop_d;

  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] remDiff;
  logic [WIDTH-1:0] absA, absB;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      signQ_q <= 1'b0;
      signR_q <= 1'b0;
      zero_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      signQ_q <= signQ_d;
      signR_q <= signR_d;
      zero_q  <= zero_d;
      stop_q  <= stop_d;
    end
  end

  // Magnitudes wrap modulo 2^WIDTH, so the most negative value stays as an unsigned 2^(WIDTH-1).
  always_comb begin
    absA     = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    absB     = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
    remShift = {rem_q, quo_q[WIDTH-1]};
    remDiff  = remShift[WIDTH-1:0] - dvs_q;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    signQ_d = signQ_q;
    signR_d = signR_q;
    zero_d  = 1'b0;
    stop_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (DivCtrl) begin
          if (B == '0) begin
            zero_d = 1'b1;
          end else begin
            signQ_d = A[WIDTH-1] ^ B[WIDTH-1];
            signR_d = A[WIDTH-1];
            quo_d   = absA;
            dvs_d   = absB;
            rem_d   = '0;
            count_d = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (remShift >= {1'b0, dvs_q}) begin
          rem_d = remDiff;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = remShift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = signQ_q ? (~quo_q + WIDTH'(1)) : quo_q;
        hi_d    = signR_q ? (~rem_q + WIDTH'(1)) : rem_q;
        stop_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign DivZero = zero_q;
  assign DivStop = stop_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: signs, zero divisor, overflow, back-to-back starts,
// mid-operation reset, and a few random pairs against a signed reference.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        DivCtrl = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        DivZero;
  logic        DivStop;
  logic [31:0] HI;
  logic [31:0] LO;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .DivCtrl (DivCtrl),
    .A       (A),
    .B       (B),
    .DivZero (DivZero),
    .DivStop (DivStop),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Entered just after a rising edge; returns just after the start edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    A = a;
    B = b;
    DivCtrl = 1'b1;
    @(posedge clk);
    #1;
    DivCtrl = 1'b0;
  endtask

  task automatic waitStop(output int latency);
    latency = 0;
    while (DivStop !== 1'b1 && latency < 40) begin
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  task automatic runDiv(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expLo, input logic [31:0] expHi);
    int lat;
    applyStimulus(a, b);
    waitStop(lat);
    checkOutput({tag, "_latency"}, lat, 33);
    checkOutput({tag, "_lo"}, LO, expLo);
    checkOutput({tag, "_hi"}, HI, expHi);
    @(posedge clk);
    #1;
    checkOutput({tag, "_stop_clear"}, DivStop, 1'b0);
  endtask

  initial begin
    int stops;
    int zeros;
    logic [31:0] ra, rb, expLo, expHi;
    int sa, sb;

    @(posedge clk);
    #1;
    checkOutput("reset_hi", HI, 32'h0);
    checkOutput("reset_lo", LO, 32'h0);
    checkOutput("reset_stop", DivStop, 1'b0);
    checkOutput("reset_zero", DivZero, 1'b0);
    reset = 1'b0;

    runDiv("pos", 32'd100, 32'd7, 32'd14, 32'd2);
    runDiv("negA", -32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    runDiv("negB", 32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1);

    applyStimulus(32'd5, 32'd0);
    checkOutput("dz_pulse", DivZero, 1'b1);
    checkOutput("dz_lo_hold", LO, 32'hFFFF_FFFD);
    checkOutput("dz_hi_hold", HI, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("dz_pulse_end", DivZero, 1'b0);
    stops = 0;
    zeros = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (DivStop) stops++;
      if (DivZero) zeros++;
    end
    checkOutput("dz_no_stop", stops, 0);
    checkOutput("dz_single", zeros, 0);
    checkOutput("dz_lo_after", LO, 32'hFFFF_FFFD);

    runDiv("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    runDiv("zeroA", 32'd0, -32'sd9, 32'd0, 32'd0);
    runDiv("bothNeg", -32'sd100, -32'sd7, 32'd14, -32'sd2);

    // DivCtrl held high: one result at E33, the next operation starts at E34.
    A = 32'd100;
    B = 32'd7;
    DivCtrl = 1'b1;
    @(posedge clk);
    #1;
    A = 32'hDEAD_BEEF;
    B = 32'd1;
    stops = 0;
    for (int n = 1; n <= 67; n++) begin
      @(posedge clk);
      #1;
      if (DivStop) stops++;
      if (n == 33) begin
        checkOutput("held_stop1", DivStop, 1'b1);
        checkOutput("held_lo1", LO, 32'd14);
        checkOutput("held_hi1", HI, 32'd2);
        A = -32'sd50;
        B = 32'd3;
      end
      if (n == 67) begin
        checkOutput("held_stop2", DivStop, 1'b1);
        checkOutput("held_lo2", LO, -32'sd16);
        checkOutput("held_hi2", HI, -32'sd2);
        DivCtrl = 1'b0;
      end
    end
    checkOutput("held_stop_count", stops, 2);
    @(posedge clk);
    #1;
    checkOutput("held_stop_clear", DivStop, 1'b0);

    // Abort after ten iterations.
    applyStimulus(32'd1000, -32'sd3);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    checkOutput("busy_lo_hold", LO, -32'sd16);
    checkOutput("busy_hi_hold", HI, -32'sd2);
    reset = 1'b1;
    #1;
    checkOutput("abort_hi", HI, 32'h0);
    checkOutput("abort_lo", LO, 32'h0);
    checkOutput("abort_stop", DivStop, 1'b0);
    #3;
    reset = 1'b0;
    stops = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (DivStop) stops++;
    end
    checkOutput("abort_no_stop", stops, 0);

    for (int k = 0; k < 4; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k == 1) rb = rb >> 20;
      if (rb == 32'h0) rb = 32'd1;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      sa = ra;
      sb = rb;
      expLo = sa / sb;
      expHi = sa % sb;
      runDiv($sformatf("rand%0d", k), ra, rb, expLo, expHi);
      checkOutput($sformatf("rand%0d_invariant", k), LO * rb + HI, ra);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
